// File: rtl/led_seq_scheduler_if.sv
// Front-end bus of the LED sequencing scheduler: control/ADC inputs, LED/AFE drive and results.
interface led_seq_scheduler_if;
    logic       enable;
    logic [7:0] ADC;
    logic [6:0] red_dc_comp;
    logic [6:0] ir_dc_comp;
    logic [3:0] red_pga;
    logic [3:0] ir_pga;
    logic       LED_RED;
    logic       LED_IR;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] RED_ADC_Value;
    logic [7:0] IR_ADC_Value;
    logic       sample_valid;
    logic       clip;
    logic       busy;

    modport master (
        output enable, ADC, red_dc_comp, ir_dc_comp, red_pga, ir_pga,
        input  LED_RED, LED_IR, DC_Comp, PGA_Gain, RED_ADC_Value, IR_ADC_Value,
               sample_valid, clip, busy
    );

    modport slave (
        input  enable, ADC, red_dc_comp, ir_dc_comp, red_pga, ir_pga,
        output LED_RED, LED_IR, DC_Comp, PGA_Gain, RED_ADC_Value, IR_ADC_Value,
               sample_valid, clip, busy
    );
endinterface

// File: rtl/led_seq_scheduler.sv
// Dark/red/IR measurement frame sequencer: drives LEDs and AFE settings, averages ADC
// samples per phase and publishes ambient-corrected channel values once per frame.
module led_seq_scheduler #(
    parameter int SETTLE_CYCLES = 3,
    parameter int SAMPLES       = 4
) (
    input  logic CLK,
    input  logic rst,
    led_seq_scheduler_if.slave bus
);
    localparam int LOG2_N = $clog2(SAMPLES);
    localparam int ACC_W  = 8 + LOG2_N;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE, DARK_SETTLE, DARK_ACQ, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ, PUBLISH
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               settle_done, acq_done, frame_start, publish;

    logic [6:0]         lat_red_dc, lat_ir_dc, lat_red_dc_nxt, lat_ir_dc_nxt;
    logic [3:0]         lat_red_pga, lat_ir_pga, lat_red_pga_nxt, lat_ir_pga_nxt;

    logic [ACC_W-1:0]   acc, acc_sum;
    logic [7:0]         acc_avg, dark_avg, red_avg;
    logic [7:0]         red_corr, ir_corr;
    logic               clip_acc, sample_clip;

    logic               led_red_nxt, led_ir_nxt, sv_nxt, busy_nxt;
    logic [6:0]         dc_nxt;
    logic [3:0]         pga_nxt;

    assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign acq_done    = (cnt == CNT_W'(SAMPLES - 1));

    // State register; cnt restarts on every state change so each phase is timed from 0.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (bus.enable)  state_nxt = DARK_SETTLE;
            DARK_SETTLE: if (settle_done) state_nxt = DARK_ACQ;
            DARK_ACQ:    if (acq_done)    state_nxt = RED_SETTLE;
            RED_SETTLE:  if (settle_done) state_nxt = RED_ACQ;
            RED_ACQ:     if (acq_done)    state_nxt = IR_SETTLE;
            IR_SETTLE:   if (settle_done) state_nxt = IR_ACQ;
            IR_ACQ:      if (acq_done)    state_nxt = PUBLISH;
            PUBLISH:     state_nxt = bus.enable ? DARK_SETTLE : IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    assign frame_start = (state_nxt == DARK_SETTLE) && (state != DARK_SETTLE);
    assign publish     = (state == IR_ACQ) && acq_done;

    // Settings captured at frame entry; the "_nxt" view lets the first SETTLE cycle use them.
    always_comb begin
        lat_red_dc_nxt  = lat_red_dc;
        lat_ir_dc_nxt   = lat_ir_dc;
        lat_red_pga_nxt = lat_red_pga;
        lat_ir_pga_nxt  = lat_ir_pga;
        if (frame_start) begin
            lat_red_dc_nxt  = bus.red_dc_comp;
            lat_ir_dc_nxt   = bus.ir_dc_comp;
            lat_red_pga_nxt = bus.red_pga;
            lat_ir_pga_nxt  = bus.ir_pga;
        end
    end

    // The first ACQ cycle starts from zero instead of the stale sum.
    assign acc_sum     = ((cnt == '0) ? '0 : acc) + ACC_W'(bus.ADC);
    assign acc_avg     = 8'(acc_sum >> LOG2_N);
    assign sample_clip = (bus.ADC == 8'd0) || (bus.ADC == 8'hFF);
    assign red_corr    = (red_avg >= dark_avg) ? (red_avg - dark_avg) : 8'd0;
    assign ir_corr     = (acc_avg >= dark_avg) ? (acc_avg - dark_avg) : 8'd0;

    always_ff @(posedge CLK) begin
        if (rst) begin
            acc         <= '0;
            dark_avg    <= '0;
            red_avg     <= '0;
            clip_acc    <= 1'b0;
            lat_red_dc  <= '0;
            lat_ir_dc   <= '0;
            lat_red_pga <= '0;
            lat_ir_pga  <= '0;
        end else begin
            lat_red_dc  <= lat_red_dc_nxt;
            lat_ir_dc   <= lat_ir_dc_nxt;
            lat_red_pga <= lat_red_pga_nxt;
            lat_ir_pga  <= lat_ir_pga_nxt;
            if (state == DARK_ACQ || state == RED_ACQ || state == IR_ACQ)
                acc <= acc_sum;
            if (state == DARK_ACQ && acq_done)
                dark_avg <= acc_avg;
            if (state == RED_ACQ && acq_done)
                red_avg <= acc_avg;
            if (frame_start)
                clip_acc <= 1'b0;
            else if ((state == RED_ACQ || state == IR_ACQ) && sample_clip)
                clip_acc <= 1'b1;
        end
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        led_red_nxt = 1'b0;
        led_ir_nxt  = 1'b0;
        dc_nxt      = '0;
        pga_nxt     = '0;
        sv_nxt      = 1'b0;
        busy_nxt    = (state_nxt != IDLE);
        case (state_nxt)
            DARK_SETTLE, DARK_ACQ: begin
                dc_nxt  = lat_red_dc_nxt;
                pga_nxt = lat_red_pga_nxt;
            end
            RED_SETTLE, RED_ACQ: begin
                led_red_nxt = 1'b1;
                dc_nxt      = lat_red_dc_nxt;
                pga_nxt     = lat_red_pga_nxt;
            end
            IR_SETTLE, IR_ACQ: begin
                led_ir_nxt = 1'b1;
                dc_nxt     = lat_ir_dc_nxt;
                pga_nxt    = lat_ir_pga_nxt;
            end
            PUBLISH: sv_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            bus.LED_RED       <= 1'b0;
            bus.LED_IR        <= 1'b0;
            bus.DC_Comp       <= '0;
            bus.PGA_Gain      <= '0;
            bus.sample_valid  <= 1'b0;
            bus.busy          <= 1'b0;
            bus.RED_ADC_Value <= '0;
            bus.IR_ADC_Value  <= '0;
            bus.clip          <= 1'b0;
        end else begin
            bus.LED_RED      <= led_red_nxt;
            bus.LED_IR       <= led_ir_nxt;
            bus.DC_Comp      <= dc_nxt;
            bus.PGA_Gain     <= pga_nxt;
            bus.sample_valid <= sv_nxt;
            bus.busy         <= busy_nxt;
            // Last IR sample arrives this cycle, so IR and clip are taken from the live sum.
            if (publish) begin
                bus.RED_ADC_Value <= red_corr;
                bus.IR_ADC_Value  <= ir_corr;
                bus.clip          <= clip_acc | sample_clip;
            end
        end
    end
endmodule

// File: tb/tb_led_seq_scheduler.sv
// Bench for led_seq_scheduler: directed frame scenarios plus random traffic against a frame-position model.
module tb_led_seq_scheduler;
    localparam int S  = 3;
    localparam int N  = 4;
    localparam int LG = 2;
    localparam int P  = S + N;
    localparam int F  = 3 * P + 1;

    logic clk, rst;
    led_seq_scheduler_if bus();

    led_seq_scheduler #(.SETTLE_CYCLES(S), .SAMPLES(N)) dut (
        .CLK(clk), .rst(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc_n = 0, sv_cnt = 0, last_sv = -1;
    bit period_chk = 0, prev_sv = 0;

    // model: frame position and per-phase sample sums
    bit m_in;
    int m_pos;
    int m_rdc, m_rpga, m_idc, m_ipga;
    int m_sum[3];
    bit m_clipf;
    int e_lr, e_li, e_dc, e_pga, e_red, e_ir, e_sv, e_clip, e_busy;

    int adc_mode = 0, d_val = 0, r_val = 0, i_val = 0;
    bit red_pat = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc_n);
    endtask

    task automatic model_step();
        int ph, da, ra, ia;
        if (rst) begin
            m_in = 0; m_pos = 0;
            m_rdc = 0; m_rpga = 0; m_idc = 0; m_ipga = 0;
            e_red = 0; e_ir = 0; e_clip = 0;
        end else begin
            ph = m_pos / P;
            if (m_in && ph < 3 && (m_pos % P) >= S) begin
                m_sum[ph] += int'(bus.ADC);
                if (ph > 0 && (bus.ADC == 8'd0 || bus.ADC == 8'd255)) m_clipf = 1;
            end
            if (!m_in || m_pos == F - 1) begin
                if (bus.enable) begin
                    m_in = 1; m_pos = 0;
                    m_rdc = bus.red_dc_comp; m_rpga = bus.red_pga;
                    m_idc = bus.ir_dc_comp;  m_ipga = bus.ir_pga;
                    m_sum[0] = 0; m_sum[1] = 0; m_sum[2] = 0; m_clipf = 0;
                end else begin
                    m_in = 0;
                end
            end else begin
                m_pos++;
            end
            if (m_in && m_pos == F - 1) begin
                da = m_sum[0] >> LG; ra = m_sum[1] >> LG; ia = m_sum[2] >> LG;
                e_red  = (ra >= da) ? ra - da : 0;
                e_ir   = (ia >= da) ? ia - da : 0;
                e_clip = m_clipf;
            end
        end
        ph = m_pos / P;
        e_busy = m_in;
        e_sv   = (m_in && m_pos == F - 1);
        e_lr = 0; e_li = 0; e_dc = 0; e_pga = 0;
        if (m_in && ph < 3) begin
            e_lr  = (ph == 1);
            e_li  = (ph == 2);
            e_dc  = (ph == 2) ? m_idc : m_rdc;
            e_pga = (ph == 2) ? m_ipga : m_rpga;
        end
    endtask

    task automatic check_all();
        chk("led_red", bus.LED_RED, e_lr);
        chk("led_ir", bus.LED_IR, e_li);
        chk("dc_comp", bus.DC_Comp, e_dc);
        chk("pga_gain", bus.PGA_Gain, e_pga);
        chk("busy", bus.busy, e_busy);
        chk("sample_valid", bus.sample_valid, e_sv);
        chk("red_value", bus.RED_ADC_Value, e_red);
        chk("ir_value", bus.IR_ADC_Value, e_ir);
        chk("clip", bus.clip, e_clip);
        chk("led_excl", bus.LED_RED & bus.LED_IR, 0);
        chk("sv_double", bus.sample_valid & prev_sv, 0);
        if (bus.sample_valid) begin
            sv_cnt++;
            if (period_chk && last_sv >= 0) chk("sv_period", cyc_n - last_sv, F);
            last_sv = cyc_n;
        end
        prev_sv = bus.sample_valid;
    endtask

    task automatic step();
        int ph, off;
        ph  = m_in ? m_pos / P : -1;
        off = m_pos % P;
        if (adc_mode == 0) begin
            if ($urandom_range(15) == 0) bus.ADC = ($urandom_range(1) == 0) ? 8'd0 : 8'd255;
            else bus.ADC = 8'($urandom_range(254, 1));
        end else begin
            case (ph)
                1:       bus.ADC = 8'((red_pat && off == S) ? 255 : r_val);
                2:       bus.ADC = 8'(i_val);
                default: bus.ADC = 8'(d_val);
            endcase
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pos(input int target);
        int k = 0;
        do begin
            step();
            k++;
        end while (!(m_in && m_pos == target) && k < 100);
        if (!(m_in && m_pos == target)) chk("wait_timeout", m_pos, target);
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 0; bus.ADC = 0;
        bus.red_dc_comp = 0; bus.ir_dc_comp = 0; bus.red_pga = 0; bus.ir_pga = 0;
        @(negedge clk);
        run(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_red_value", bus.RED_ADC_Value, 0);
        rst = 1'b0;

        // steady frames with fixed per-phase levels
        bus.red_dc_comp = 5; bus.red_pga = 3; bus.ir_dc_comp = 9; bus.ir_pga = 2;
        adc_mode = 1; d_val = 10; r_val = 150; i_val = 90;
        bus.enable = 1; period_chk = 1; last_sv = -1; sv_cnt = 0;
        run(3 * F);
        period_chk = 0;
        chk("steady_nsv", sv_cnt, 3);
        chk("steady_red", bus.RED_ADC_Value, 140);
        chk("steady_ir", bus.IR_ADC_Value, 80);
        chk("steady_clip", bus.clip, 0);

        // dark above IR saturates; 255 in red sets clip
        d_val = 100; r_val = 200; i_val = 60; red_pat = 1;
        run(F);
        red_pat = 0;
        chk("sat_red", bus.RED_ADC_Value, 113);
        chk("sat_ir", bus.IR_ADC_Value, 0);
        chk("sat_clip", bus.clip, 1);

        // PGA change mid-frame lands next frame
        d_val = 10; r_val = 150; i_val = 90;
        wait_pos(P + S + 1);
        bus.red_pga = 7;
        step();
        chk("pga_hold", bus.PGA_Gain, 3);
        wait_pos(P + S);
        chk("pga_new", bus.PGA_Gain, 7);

        // enable dropped in RED_ACQ: frame completes then idles
        bus.enable = 0; sv_cnt = 0;
        run(30);
        chk("drop_nsv", sv_cnt, 1);
        chk("drop_busy", bus.busy, 0);

        // reset during IR_SETTLE abandons the frame
        bus.enable = 1;
        wait_pos(2 * P + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_led_ir", bus.LED_IR, 0);
        chk("abort_red_value", bus.RED_ADC_Value, 0);
        sv_cnt = 0;
        run(F);
        chk("restart_nsv", sv_cnt, 1);
        chk("restart_red", bus.RED_ADC_Value, 140);

        // random traffic
        adc_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) bus.enable = ~bus.enable;
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(29) == 0) begin
                bus.red_dc_comp = 7'($urandom); bus.ir_dc_comp = 7'($urandom);
                bus.red_pga = 4'($urandom);     bus.ir_pga = 4'($urandom);
            end
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/led_seq_scheduler.md
LED_SEQ_SCHEDULER -- requirements
Module: led_seq_scheduler

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 3, giving the LED/analog settling cycles per phase (range 1..15).
REQ-002 The block SHALL have parameter SAMPLES, default 4, giving the ADC samples averaged per phase (power of two, 2..16).
REQ-003 The block SHALL have a single clock domain and a synchronous, active-high reset; the ports are as listed below, clock and reset first.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  run continuous frames while high.
REQ-007 ADC  in  8  unsigned front-end ADC sample.
REQ-008 red_dc_comp / ir_dc_comp  in  7  DC compensation code per channel.
REQ-009 red_pga / ir_pga  in  4  PGA gain code per channel.
REQ-010 LED_RED, LED_IR  out  1  LED enables.
REQ-011 DC_Comp  out  7  DC compensation code applied to the analog front end.
REQ-012 PGA_Gain  out  4  PGA gain code applied to the analog front end.
REQ-013 RED_ADC_Value, IR_ADC_Value  out  8  ambient-corrected channel averages.
REQ-014 sample_valid  out  1  one-cycle pulse when new values are published.
REQ-015 clip  out  1  a RED/IR sample of the frame hit 0 or 255; valid alongside sample_valid.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, DARK_SETTLE, DARK_ACQ, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ, PUBLISH, with all outputs registered.
REQ-018 IDLE -> DARK_SETTLE SHALL occur on the edge where enable=1; otherwise the block remains in IDLE.
REQ-019 On entering DARK_SETTLE, red_dc_comp, red_pga, ir_dc_comp and ir_pga SHALL be latched; input changes mid-frame SHALL take effect at the next frame only.
REQ-020 Each *_SETTLE state SHALL last exactly SETTLE_CYCLES cycles; no ADC capture.
REQ-021 Each *_ACQ state SHALL last exactly SAMPLES cycles; ADC is accumulated once per cycle.
REQ-022 Order: DARK_SETTLE -> DARK_ACQ -> RED_SETTLE -> RED_ACQ -> IR_SETTLE -> IR_ACQ -> PUBLISH; frame length = 3*(SETTLE_CYCLES+SAMPLES)+1 cycles.
REQ-023 DARK_*: LED_RED=0, LED_IR=0, DC_Comp/PGA_Gain = latched red settings.
REQ-024 RED_*: LED_RED=1, LED_IR=0, latched red settings; IR_*: LED_RED=0, LED_IR=1, latched IR settings.
REQ-025 LED and setting outputs SHALL be valid in the first cycle of each SETTLE state, and the two LEDs SHALL never be high in the same cycle.
REQ-026 Accumulator width SHALL be 8+log2(SAMPLES) bits, cleared at each ACQ entry, with no overflow possible.
REQ-027 Average = accumulator >> log2(SAMPLES), truncating.
REQ-028 Corrected value = avg - dark_avg if avg >= dark_avg, else 0 (saturating, 8 bits).
REQ-029 PUBLISH (1 cycle): LEDs off, DC_Comp=0, PGA_Gain=0; sample_valid=1; RED/IR_ADC_Value and clip update and hold until the next PUBLISH.
REQ-030 clip SHALL be set if any RED_ACQ or IR_ACQ sample equals 0 or 255; DARK samples are ignored; clip is cleared at frame start.
REQ-031 From PUBLISH the block SHALL go to DARK_SETTLE if enable=1, else IDLE.
REQ-032 Deasserting enable mid-frame SHALL let the frame complete, including PUBLISH, before IDLE is entered.
REQ-033 In IDLE: LEDs off, DC_Comp=0, PGA_Gain=0, sample_valid=0; last published values are held.

Reset
REQ-034 rst=1 SHALL force IDLE on the next edge from any state, overriding enable and abandoning any frame.
REQ-035 Reset values: LED_RED=0, LED_IR=0, DC_Comp=0, PGA_Gain=0, RED_ADC_Value=0, IR_ADC_Value=0, sample_valid=0, clip=0, busy=0; counters, accumulators and latched settings are 0.
REQ-036 A frame aborted by reset SHALL publish nothing.

Verification (defaults: SETTLE=3, SAMPLES=4, frame=22 cycles)
REQ-037 Stimulus: enable held high; ADC=10 in dark, 150 in red, 90 in IR. Required: sample_valid every 22 cycles; RED_ADC_Value=140, IR_ADC_Value=80, clip=0.
REQ-038 Stimulus: dark ADC=100, IR ADC=60. Required: IR_ADC_Value=0 by saturation. Stimulus: red samples 255,200,200,200. Required: clip=1, RED_ADC_Value=213-dark, with 855>>2=213.
REQ-039 Stimulus: red_pga changed from 3 to 7 during RED_ACQ. Required: PGA_Gain stays 3 this frame, 7 in the next frame's RED phases.
REQ-040 Stimulus: enable dropped during RED_ACQ. Required: frame completes, one sample_valid, then IDLE with busy=0.
REQ-041 Stimulus: rst pulsed during IR_SETTLE. Required: next cycle LEDs=0, busy=0, no sample_valid, outputs at reset values; a new frame restarts cleanly.
REQ-042 Check every cycle: LED_RED & LED_IR never both 1; sample_valid never high for two consecutive cycles.
